// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: I/O region tag, address
// decode helper and master-id width.
package bus_pkg;

  localparam logic [1:0] IO_TAG = 2'b11;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The I/O window is the top quarter just above the RAM address span.
  function automatic logic is_io(input logic [63:0] addr, input int ram_aw);
    logic [63:0] sh;
    sh = addr >> (ram_aw - 1);
    return sh[1:0] == IO_TAG;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// Round-robin arbiter: picks the first requester at or after ptr_i (wrapping)
// and returns the one-hot grant plus the pointer just past the winner.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] ptr_nxt_o
);

  int   idx;
  logic found;

  always_comb begin
    gnt_o     = '0;
    ptr_nxt_o = ptr_i;
    found     = 1'b0;
    idx       = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr_i) + off) % N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
        ptr_nxt_o  = PTR_W'((idx + 1) % N);
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates N byte-wide masters onto one RAM port and one memory-mapped I/O
// port; master 0 has strict priority and an exclusive mode.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 8,
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int IO_SEL_WIDTH   = 3
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              excl_in,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]            m_wr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]            m_gnt,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic                              ram_en,
  output logic                              ram_r_nw,
  output logic [RAM_ADDR_WIDTH-1:0]         ram_a,
  output logic [DATA_WIDTH-1:0]             ram_wdata,
  input  logic [DATA_WIDTH-1:0]             ram_rdata,
  output logic                              io_en,
  output logic [IO_SEL_WIDTH-1:0]           io_sel,
  output logic                              io_wr,
  output logic [DATA_WIDTH-1:0]             io_wdata,
  input  logic [DATA_WIDTH-1:0]             io_rdata,
  input  logic                              io_full
);

  localparam int ID_W = id_width(NUM_MASTERS);

  logic [NUM_MASTERS-1:0]    is_io_v, elig, rr_req, rr_gnt, gnt;
  logic [ID_W-1:0]           rr_ptr_q, rr_ptr_d, rr_ptr_nxt, sel_id;
  logic [ID_W-1:0]           pend_id_q, pend_id_d;
  logic                      pend_valid_q, pend_valid_d, pend_io_q, pend_io_d;
  logic                      any_gnt, sel_wr, sel_io;
  logic [RAM_ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]     sel_wdata;

  // Eligibility; reset suppresses every request so nothing is granted.
  always_comb begin
    is_io_v = '0;
    elig    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      is_io_v[i] = is_io(64'(m_addr[i*ADDR_WIDTH +: ADDR_WIDTH]), RAM_ADDR_WIDTH);
      elig[i]    = m_req[i] & ~rst_in & ~(is_io_v[i] & m_wr[i] & io_full)
                   & ~(excl_in & (i != 0));
    end
    rr_req    = elig;
    rr_req[0] = 1'b0;
  end

  rr_arbiter #(.N(NUM_MASTERS), .PTR_W(ID_W)) u_rr (
    .req_i     (rr_req),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (rr_gnt),
    .ptr_nxt_o (rr_ptr_nxt)
  );

  always_comb begin
    gnt       = '0;
    rr_ptr_d  = rr_ptr_q;
    sel_id    = '0;
    sel_addr  = '0;
    sel_wr    = 1'b0;
    sel_wdata = '0;
    sel_io    = 1'b0;
    if (elig[0]) begin
      gnt[0] = 1'b1;
    end else if (|rr_gnt) begin
      gnt = rr_gnt;
      // Master 0 sits outside the rotation, so a wrap to 0 lands on 1.
      rr_ptr_d = (rr_ptr_nxt == '0) ? ID_W'(1) : rr_ptr_nxt;
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt[i]) begin
        sel_id    = ID_W'(i);
        sel_addr  = m_addr[i*ADDR_WIDTH +: RAM_ADDR_WIDTH];
        sel_wr    = m_wr[i];
        sel_wdata = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_io    = is_io_v[i];
      end
    end
    any_gnt      = |gnt;
    pend_valid_d = any_gnt & ~sel_wr;
    pend_id_d    = sel_id;
    pend_io_d    = sel_io;
  end

  assign m_gnt     = gnt;
  assign ram_en    = any_gnt & ~sel_io;
  assign ram_r_nw  = ~(any_gnt & sel_wr);
  assign ram_a     = sel_addr;
  assign ram_wdata = sel_wdata;
  assign io_en     = any_gnt & sel_io;
  assign io_sel    = sel_addr[IO_SEL_WIDTH-1:0];
  assign io_wr     = any_gnt & sel_io & sel_wr;
  assign io_wdata  = sel_wdata;

  always_comb begin
    m_rvalid = '0;
    m_rdata  = '0;
    if (pend_valid_q && !rst_in) begin
      m_rdata = pend_io_q ? io_rdata : ram_rdata;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (pend_id_q == ID_W'(i)) m_rvalid[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr_q     <= ID_W'(1);
      pend_valid_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  // Read-return tag is qualified by pend_valid_q, so it needs no reset.
  always_ff @(posedge clk_in) begin
    pend_id_q <= pend_id_d;
    pend_io_q <= pend_io_d;
  end

endmodule
